// File: rtl/ordering_ram_pkg.sv
// Shared sizing and types for the per-replica tour ordering store.
package ordering_ram_pkg;

  localparam int city_num     = 8;
  localparam int city_num_log = 4;

  typedef logic [city_num_log-1:0] city_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_HI = 3'd3,
    ST_WR_LO = 3'd4,
    ST_FIN   = 3'd5
  } ordering_state_t;

endpackage

// File: rtl/ordering_mem.sv
// Tour position RAM: one synchronous read port, one write port, read-first, no reset.
module ordering_mem #(
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rdata_q;

  // The read samples pre-write contents, so a same-address collision returns old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ordering_ram.sv
// Per-replica tour store: host preload, 1-cycle reads, in-place 2-opt segment reversal.
// Build option ORDERING_REVERSE_EN enables the reversal FSM; otherwise preload/read only.
module ordering_ram_chk #(
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input logic          clk,
  input logic          reset,
  input logic          ordering_read,
  input logic          rev_start,
  input logic          rev_busy,
  input logic [AW-1:0] rev_k,
  input logic [AW-1:0] rev_l
);

  localparam logic [AW-1:0] LAST_POS = AW'(DEPTH - 1);
  localparam logic [AW-1:0] MAX_L    = AW'(DEPTH - 2);

  a_read_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(ordering_read && rev_busy))
    else $error("ordering_read issued while rev_busy");

  a_start_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(rev_start && rev_busy))
    else $error("rev_start issued while rev_busy");

  a_move_indices: assert property (@(posedge clk) disable iff (reset)
    (rev_start && !rev_busy) |-> ((rev_k != LAST_POS) && (rev_l <= MAX_L)))
    else $error("rev_k/rev_l outside the legal tour range");

endmodule

module ordering_ram
  import ordering_ram_pkg::*;
#(
  parameter int DEPTH = city_num + 2,
  parameter int AW    = city_num_log
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tp_ord_write,
  input  logic [AW-1:0] tp_ord_waddr,
  input  logic [AW-1:0] tp_ord_wdata,
  input  logic          ordering_read,
  input  logic [AW-1:0] ordering_addr,
  output logic [AW-1:0] ordering_data,
  input  logic          rev_start,
  input  logic [AW-1:0] rev_k,
  input  logic [AW-1:0] rev_l,
  output logic          rev_busy,
  output logic          rev_done,
  output logic          wr_drop
);

  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic          pre_we, host_rd;
  logic          fsm_we, fsm_re;
  logic [AW-1:0] fsm_waddr, fsm_wdata, fsm_raddr;
  logic          host_sel_q, host_sel_d;
  logic [AW-1:0] data_hold_q, data_hold_d;

`ifdef ORDERING_REVERSE_EN
  localparam logic [AW-1:0] ONE = AW'(1);

  ordering_state_t state_q, state_d;
  logic [AW-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic [AW-1:0]   tmp_lo_q, tmp_lo_d, tmp_hi_q, tmp_hi_d;
  logic [AW-1:0]   lo_inc, hi_dec, start_lo;
  logic            rev_busy_q, rev_busy_d;
  logic            rev_done_q, rev_done_d;
  logic            wr_drop_q, wr_drop_d;

  // Swap walk: read lo, read hi, write hi, write lo, then step both ends inward.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    tmp_lo_d  = tmp_lo_q;
    tmp_hi_d  = tmp_hi_q;
    fsm_we    = 1'b0;
    fsm_re    = 1'b0;
    fsm_waddr = lo_q;
    fsm_wdata = tmp_hi_q;
    fsm_raddr = lo_q;
    lo_inc    = lo_q + ONE;
    hi_dec    = hi_q - ONE;
    start_lo  = rev_k + ONE;
    case (state_q)
      ST_IDLE: begin
        if (rev_start) begin
          lo_d    = start_lo;
          hi_d    = rev_l;
          state_d = (start_lo >= rev_l) ? ST_FIN : ST_RD_LO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_LO: begin
        fsm_re    = 1'b1;
        fsm_raddr = lo_q;
        state_d   = ST_RD_HI;
      end
      ST_RD_HI: begin
        fsm_re    = 1'b1;
        fsm_raddr = hi_q;
        tmp_lo_d  = mem_rdata;
        state_d   = ST_WR_HI;
      end
      ST_WR_HI: begin
        fsm_we    = 1'b1;
        fsm_waddr = hi_q;
        fsm_wdata = tmp_lo_q;
        tmp_hi_d  = mem_rdata;
        state_d   = ST_WR_LO;
      end
      ST_WR_LO: begin
        fsm_we    = 1'b1;
        fsm_waddr = lo_q;
        fsm_wdata = tmp_hi_q;
        lo_d      = lo_inc;
        hi_d      = hi_dec;
        state_d   = (lo_inc < hi_dec) ? ST_RD_LO : ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rev_busy_d = (state_d != ST_IDLE);
    rev_done_d = (state_q == ST_FIN);
    wr_drop_d  = tp_ord_write && (state_q != ST_IDLE);
    pre_we     = tp_ord_write && (state_q == ST_IDLE);
    host_rd    = ordering_read && !rev_busy_q;
  end

  // FSM state, swap registers and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      tmp_lo_q   <= '0;
      tmp_hi_q   <= '0;
      rev_busy_q <= 1'b0;
      rev_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      tmp_lo_q   <= tmp_lo_d;
      tmp_hi_q   <= tmp_hi_d;
      rev_busy_q <= rev_busy_d;
      rev_done_q <= rev_done_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign rev_busy = rev_busy_q;
  assign rev_done = rev_done_q;
  assign wr_drop  = wr_drop_q;

  ordering_ram_chk #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .ordering_read (ordering_read),
    .rev_start     (rev_start),
    .rev_busy      (rev_busy_q),
    .rev_k         (rev_k),
    .rev_l         (rev_l)
  );
`else
  logic unused_rev;

  assign unused_rev = ^{rev_start, rev_k, rev_l};
  assign fsm_we     = 1'b0;
  assign fsm_re     = 1'b0;
  assign fsm_waddr  = '0;
  assign fsm_wdata  = '0;
  assign fsm_raddr  = '0;
  assign pre_we     = tp_ord_write;
  assign host_rd    = ordering_read;
  assign rev_busy   = 1'b0;
  assign rev_done   = 1'b0;
  assign wr_drop    = 1'b0;
`endif

  // The reversal owns the RAM ports while busy; ordering_data only follows host reads.
  always_comb begin
    mem_we        = fsm_we | pre_we;
    mem_waddr     = fsm_we ? fsm_waddr : tp_ord_waddr;
    mem_wdata     = fsm_we ? fsm_wdata : tp_ord_wdata;
    mem_re        = fsm_re | host_rd;
    mem_raddr     = fsm_re ? fsm_raddr : ordering_addr;
    host_sel_d    = host_rd;
    ordering_data = host_sel_q ? mem_rdata : data_hold_q;
    data_hold_d   = ordering_data;
  end

  // Remembers whether the RAM output is a fresh host read, else replays the held value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_sel_q  <= 1'b0;
      data_hold_q <= '0;
    end else begin
      host_sel_q  <= host_sel_d;
      data_hold_q <= data_hold_d;
    end
  end

  ordering_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ordering_ram.sv
// Bench for ordering_ram: table-driven preload/read vectors, hand-written reversal corner
// cases, and a randomized phase checked against an array model of the tour.
module tb_ordering_ram;
  import ordering_ram_pkg::*;

  localparam int DEPTH = city_num + 2;
  localparam int AW    = city_num_log;

  logic          clk = 1'b0;
  logic          reset;
  logic          tp_ord_write;
  logic [AW-1:0] tp_ord_waddr, tp_ord_wdata;
  logic          ordering_read;
  logic [AW-1:0] ordering_addr;
  logic [AW-1:0] ordering_data;
  logic          rev_start;
  logic [AW-1:0] rev_k, rev_l;
  logic          rev_busy, rev_done, wr_drop;

  int n_cmp = 0;
  int n_err = 0;
  int ref_mem [DEPTH];
  int tour    [DEPTH] = '{0, 3, 1, 4, 2, 5, 6, 7, 8, 0};
  int rev_exp [DEPTH] = '{0, 3, 6, 5, 2, 4, 1, 7, 8, 0};

  typedef struct {
    bit wr;
    int waddr;
    int wdata;
    bit rd;
    int raddr;
    int exp;
  } vec_t;
  vec_t vecs[$];

  ordering_ram #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .tp_ord_write  (tp_ord_write),
    .tp_ord_waddr  (tp_ord_waddr),
    .tp_ord_wdata  (tp_ord_wdata),
    .ordering_read (ordering_read),
    .ordering_addr (ordering_addr),
    .ordering_data (ordering_data),
    .rev_start     (rev_start),
    .rev_k         (rev_k),
    .rev_l         (rev_l),
    .rev_busy      (rev_busy),
    .rev_done      (rev_done),
    .wr_drop       (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input int d);
    tp_ord_write = 1'b1;
    tp_ord_waddr = AW'(a);
    tp_ord_wdata = AW'(d);
    step();
    tp_ord_write = 1'b0;
    ref_mem[a]   = d;
  endtask

  task automatic read_check(input string name, input int a, input int exp);
    ordering_read = 1'b1;
    ordering_addr = AW'(a);
    step();
    ordering_read = 1'b0;
    check(name, 32'(ordering_data), exp);
  endtask

  task automatic readback(input string name);
    for (int p = 0; p < DEPTH; p++) begin
      read_check($sformatf("%s pos%0d", name, p), p, ref_mem[p]);
    end
  endtask

  // Reverse positions k+1..l of the model and expect 4*floor((l-k)/2)+2 cycles to rev_done.
  task automatic run_rev(input string name, input int k, input int l, input bit drop);
    int cnt;
    int i;
    int j;
    int t;
    rev_k     = AW'(k);
    rev_l     = AW'(l);
    rev_start = 1'b1;
    step();
    rev_start = 1'b0;
    cnt       = 1;
    check($sformatf("%s busy", name), 32'(rev_busy), 32'd1);
    if (drop) begin
      tp_ord_write = 1'b1;
      tp_ord_waddr = AW'(8);
      tp_ord_wdata = AW'(9);
      step();
      tp_ord_write = 1'b0;
      cnt++;
      check($sformatf("%s wr_drop", name), 32'(wr_drop), 32'd1);
    end
    while (rev_done !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    check($sformatf("%s cycles", name), 32'(cnt), 32'(4 * ((l - k) / 2) + 2));
    check($sformatf("%s busy_at_done", name), 32'(rev_busy), 32'd0);
    i = k + 1;
    j = l;
    while (i < j) begin
      t          = ref_mem[i];
      ref_mem[i] = ref_mem[j];
      ref_mem[j] = t;
      i++;
      j--;
    end
    step();
    check($sformatf("%s done_pulse", name), 32'(rev_done), 32'd0);
  endtask

  initial begin
    int op, a, d, k, l;
    reset         = 1'b1;
    tp_ord_write  = 1'b0;
    tp_ord_waddr  = '0;
    tp_ord_wdata  = '0;
    ordering_read = 1'b0;
    ordering_addr = '0;
    rev_start     = 1'b0;
    rev_k         = '0;
    rev_l         = '0;
    step();
    step();
    check("reset ordering_data", 32'(ordering_data), 32'd0);
    check("reset rev_busy", 32'(rev_busy), 32'd0);
    check("reset rev_done", 32'(rev_done), 32'd0);
    check("reset wr_drop", 32'(wr_drop), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) vecs.push_back('{1'b1, i, tour[i], 1'b0, 0, 0});
    vecs.push_back('{1'b0, 0, 0, 1'b1, 4, 2});
    vecs.push_back('{1'b0, 0, 0, 1'b0, 0, 2});
    vecs.push_back('{1'b0, 0, 0, 1'b1, 1, 3});
    vecs.push_back('{1'b0, 0, 0, 1'b1, 9, 0});
    vecs.push_back('{1'b1, 2, 7, 1'b1, 2, 1});
    vecs.push_back('{1'b0, 0, 0, 1'b1, 2, 7});
    vecs.push_back('{1'b1, 2, 1, 1'b0, 0, 7});
    vecs.push_back('{1'b0, 0, 0, 1'b1, 2, 1});
    foreach (vecs[i]) begin
      tp_ord_write  = vecs[i].wr;
      tp_ord_waddr  = AW'(vecs[i].waddr);
      tp_ord_wdata  = AW'(vecs[i].wdata);
      ordering_read = vecs[i].rd;
      ordering_addr = AW'(vecs[i].raddr);
      step();
      if (vecs[i].wr) ref_mem[vecs[i].waddr] = vecs[i].wdata;
      check($sformatf("vec%0d data", i), 32'(ordering_data), 32'(vecs[i].exp));
    end
    tp_ord_write  = 1'b0;
    ordering_read = 1'b0;

`ifdef ORDERING_REVERSE_EN
    run_rev("even", 1, 6, 1'b1);
    for (int p = 0; p < DEPTH; p++) begin
      read_check($sformatf("even pos%0d", p), p, rev_exp[p]);
    end
    run_rev("degen", 3, 4, 1'b0);
    readback("degen");

    rev_k     = AW'(1);
    rev_l     = AW'(6);
    rev_start = 1'b1;
    step();
    rev_start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("midreset busy", 32'(rev_busy), 32'd0);
    check("midreset done", 32'(rev_done), 32'd0);
    check("midreset data", 32'(ordering_data), 32'd0);
    step();
    reset = 1'b0;
    for (int p = 0; p < DEPTH; p++) preload(p, ref_mem[p]);
    check("reload wr_drop", 32'(wr_drop), 32'd0);
    run_rev("fresh", 0, 8, 1'b0);
    readback("fresh");
`else
    rev_k     = AW'(1);
    rev_l     = AW'(6);
    rev_start = 1'b1;
    step();
    rev_start = 1'b0;
    check("norev busy", 32'(rev_busy), 32'd0);
    preload(8, 9);
    check("norev wr_drop", 32'(wr_drop), 32'd0);
    repeat (12) begin
      step();
      if (rev_done !== 1'b0) break;
    end
    check("norev done", 32'(rev_done), 32'd0);
    readback("norev");
    reset = 1'b1;
    #1;
    check("midreset data", 32'(ordering_data), 32'd0);
    step();
    reset = 1'b0;
    readback("after_reset");
`endif

    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 2));
`ifdef ORDERING_REVERSE_EN
      if (op == 2) begin
        k = int'($urandom_range(0, DEPTH - 3));
        l = int'($urandom_range(k + 1, DEPTH - 2));
        run_rev($sformatf("rnd%0d rev", it), k, l, 1'b0);
        readback($sformatf("rnd%0d", it));
        continue;
      end
`endif
      a = int'($urandom_range(0, DEPTH - 1));
      if (op == 0) begin
        d = int'($urandom_range(0, (1 << AW) - 1));
        preload(a, d);
      end else begin
        read_check($sformatf("rnd%0d read", it), a, ref_mem[a]);
      end
    end
    readback("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
